// File: rtl/hazard_sched.sv
// hazard_sched: pipeline sequencer for the SIMPLE core.
// Each cycle it decides whether fetch advances, stalls, flushes or freezes. It covers
// load-use stalls, taken-branch flushes, the IN/OUT device handshake and HLT. It also
// keeps saturating stall and flush counters.
module hazard_sched #(
    parameter int CNT_W      = 16,
    parameter int IO_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_halt,
    input  logic             id_io,
    input  logic             ex_memread,
    input  logic [2:0]       ex_dst,
    input  logic             br_taken,
    input  logic             io_ack,
    input  logic             clr_stats,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             io_req,
    output logic             io_err,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int TO_W = $clog2(IO_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {S_RUN, S_IO_WAIT, S_HALTED} state_t;

    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_io_err;
    logic              r_io_req;
    logic              r_halted;
    logic [CNT_W-1:0]  r_stall;
    logic [CNT_W-1:0]  r_flush;

    state_t            w_state_next;
    logic              w_hazard;
    logic              w_pc_en;
    logic              w_ifid_en;
    logic              w_ifid_flush;
    logic              w_idex_bubble;
    logic              w_to_clr;
    logic              w_to_inc;
    logic              w_set_err;
    logic              w_flush_inc;
    logic              w_stall_inc;

    assign w_hazard = ex_memread && id_valid &&
                      ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));

    // Per-cycle pipeline decision; the default is a frozen front end with a bubble into EX.
    always_comb begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b1;
        w_state_next  = r_state;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;
        w_set_err     = 1'b0;
        w_flush_inc   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (br_taken) begin
                    // Wrong-path ID instruction (even HLT/IO) is squashed.
                    w_pc_en      = 1'b1;
                    w_ifid_en    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_flush_inc  = 1'b1;
                end else if (id_valid && id_halt) begin
                    w_state_next = S_HALTED;
                end else if (w_hazard) begin
                    // One bubble suffices: the LD reaches MEM next cycle.
                end else if (id_valid && id_io) begin
                    w_state_next = S_IO_WAIT;
                    w_to_clr     = 1'b1;
                end else begin
                    w_pc_en       = 1'b1;
                    w_ifid_en     = 1'b1;
                    w_idex_bubble = 1'b0;
                end
            end
            S_IO_WAIT: begin
                if (io_ack || (r_to_cnt == TO_LAST)) begin
                    // Release lets the IO instruction proceed into EX.
                    w_pc_en       = 1'b1;
                    w_ifid_en     = 1'b1;
                    w_idex_bubble = 1'b0;
                    w_state_next  = S_RUN;
                    w_set_err     = !io_ack;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_HALTED: begin
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    assign w_stall_inc = (r_state != S_HALTED) && !w_pc_en;

    // Control outputs are forced to the frozen/bubble pattern while reset is held.
    assign pc_en        = w_pc_en && !rst;
    assign ifid_en      = w_ifid_en && !rst;
    assign ifid_flush   = w_ifid_flush && !rst;
    assign idex_bubble  = w_idex_bubble || rst;
    assign io_req       = r_io_req;
    assign io_err       = r_io_err;
    assign halted       = r_halted;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;

    // Sequencer state, IO timeout counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_to_cnt <= '0;
            r_io_err <= 1'b0;
            r_io_req <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_io_req <= (w_state_next == S_IO_WAIT);
            r_halted <= (w_state_next == S_HALTED);
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_set_err) begin
                r_io_err <= 1'b1;
            end
        end
    end

    // Saturating performance counters; a clear wins over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (clr_stats) begin
                r_stall <= '0;
            end else if (w_stall_inc && !(&r_stall)) begin
                r_stall <= r_stall + 1'b1;
            end
            if (clr_stats) begin
                r_flush <= '0;
            end else if (w_flush_inc && !(&r_flush)) begin
                r_flush <= r_flush + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: a decision table, directed multi-cycle scenarios and
// randomized traffic checked against a rule-level reference model.
module tb_hazard_sched;
    localparam int CNT_W   = 4;
    localparam int TO      = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid, id_use_rs, id_use_rt, id_halt, id_io;
    logic [2:0]       id_rs, id_rt, ex_dst;
    logic             ex_memread, br_taken, io_ack, clr_stats;
    logic             pc_en, ifid_en, ifid_flush, idex_bubble, io_req, io_err, halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    hazard_sched #(.CNT_W(CNT_W), .IO_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt), .id_io(id_io),
        .ex_memread(ex_memread), .ex_dst(ex_dst), .br_taken(br_taken), .io_ack(io_ack),
        .clr_stats(clr_stats), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .io_req(io_req), .io_err(io_err), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       halt;
        logic       io;
        logic       memread;
        logic [2:0] dst;
        logic       br;
        logic       ack;
        logic       clr;
    } stim_t;

    typedef struct packed {
        stim_t s;
        logic  pc;
        logic  ifid;
        logic  fl;
        logic  bub;
        logic  nxt_halted;
        logic  nxt_io_req;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0=RUN 1=IO_WAIT 2=HALTED
    int m_mode, m_waited, m_stall, m_flush;
    bit m_err;
    bit e_pc, e_ifid, e_fl, e_bub;
    int e_next;
    bit e_timeout, e_flush_inc;

    function automatic stim_t mk(input bit v, input int rs, input int rt, input bit urs,
                                 input bit urt, input bit h, input bit io, input bit mr,
                                 input int dst, input bit br, input bit ack, input bit clr);
        stim_t s;
        s.valid = v; s.rs = 3'(rs); s.rt = 3'(rt); s.use_rs = urs; s.use_rt = urt;
        s.halt = h; s.io = io; s.memread = mr; s.dst = 3'(dst); s.br = br;
        s.ack = ack; s.clr = clr;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        id_valid = s.valid; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs;
        id_use_rt = s.use_rt; id_halt = s.halt; id_io = s.io; ex_memread = s.memread;
        ex_dst = s.dst; br_taken = s.br; io_ack = s.ack; clr_stats = s.clr;
    endtask

    // Decide the expected action from the current model mode and inputs.
    task automatic model_eval(input stim_t s);
        bit lu;
        bit adv;
        lu = s.memread && s.valid &&
             ((s.use_rs && s.rs == s.dst) || (s.use_rt && s.rt == s.dst));
        e_fl = 0; e_timeout = 0; e_flush_inc = 0; adv = 0; e_next = m_mode;
        if (m_mode == 1) begin
            if (s.ack) begin adv = 1; e_next = 0; end
            else if (m_waited + 1 >= TO) begin adv = 1; e_next = 0; e_timeout = 1; end
        end else if (m_mode == 0) begin
            if (s.br) begin adv = 1; e_fl = 1; e_flush_inc = 1; end
            else if (s.valid && s.halt) e_next = 2;
            else if (lu) e_next = 0;
            else if (s.valid && s.io) e_next = 1;
            else adv = 1;
        end
        e_pc = adv;
        e_ifid = adv;
        e_bub = !adv || e_fl;
    endtask

    task automatic model_commit(input stim_t s);
        if (s.clr) m_stall = 0;
        else if (m_mode != 2 && !e_pc && m_stall < CNT_MAX) m_stall++;
        if (s.clr) m_flush = 0;
        else if (e_flush_inc && m_flush < CNT_MAX) m_flush++;
        if (e_timeout) m_err = 1;
        if (e_next == 1) m_waited = (m_mode == 1) ? m_waited + 1 : 0;
        m_mode = e_next;
    endtask

    // One clocked step: drive, check every output at the falling edge, advance model.
    task automatic cycle(input stim_t s);
        apply(s);
        @(negedge clk);
        model_eval(s);
        check("pc_en", 32'(pc_en), 32'(e_pc));
        check("ifid_en", 32'(ifid_en), 32'(e_ifid));
        check("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check("io_req", 32'(io_req), 32'(m_mode == 1));
        check("halted", 32'(halted), 32'(m_mode == 2));
        check("io_err", 32'(io_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("flush_count", 32'(flush_count), 32'(m_flush));
        @(posedge clk);
        model_commit(s);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_ifid_en", 32'(ifid_en), 32'd0);
        check("rst_ifid_flush", 32'(ifid_flush), 32'd0);
        check("rst_idex_bubble", 32'(idex_bubble), 32'd1);
        check("rst_io_req", 32'(io_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
    endtask

    vec_t  tbl[12];
    stim_t idle, s_lu, s_io, s_halt, s_r;
    int    n;

    initial begin
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_lu   = mk(1, 1, 3, 0, 1, 0, 0, 1, 3, 0, 0, 0);
        s_io   = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        s_halt = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply(idle);

        //              stimulus                                          pc if fl bu  H  IO
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 1, 1, 1, 1, 0, 0};
        tbl[2]  = '{mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 0};
        tbl[3]  = '{mk(1, 1, 3, 0, 1, 0, 0, 1, 3, 0, 0, 0), 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{mk(1, 5, 0, 0, 1, 0, 0, 1, 5, 0, 0, 0), 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{mk(0, 2, 2, 1, 1, 0, 0, 1, 2, 0, 0, 0), 1, 1, 0, 0, 0, 0};
        tbl[6]  = '{mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1};
        tbl[7]  = '{mk(1, 4, 4, 1, 0, 1, 1, 1, 4, 0, 0, 0), 0, 0, 0, 1, 1, 0};
        tbl[8]  = '{mk(1, 6, 0, 1, 0, 0, 1, 1, 6, 0, 0, 0), 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0};
        tbl[10] = '{mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0), 1, 1, 1, 1, 0, 0};
        tbl[11] = '{mk(1, 1, 2, 1, 1, 0, 0, 1, 7, 0, 0, 0), 1, 1, 0, 0, 0, 0};

        // Decision table: each row from a fresh RUN state.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            apply(tbl[i].s);
            @(negedge clk);
            check($sformatf("tbl%0d_pc_en", i), 32'(pc_en), 32'(tbl[i].pc));
            check($sformatf("tbl%0d_ifid_en", i), 32'(ifid_en), 32'(tbl[i].ifid));
            check($sformatf("tbl%0d_ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
            check($sformatf("tbl%0d_idex_bubble", i), 32'(idex_bubble), 32'(tbl[i].bub));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].nxt_halted));
            check($sformatf("tbl%0d_io_req", i), 32'(io_req), 32'(tbl[i].nxt_io_req));
            apply(idle);
        end

        // Load-use: one stall cycle, then the LD has left EX.
        do_reset();
        cycle(s_lu);
        s_r = s_lu; s_r.memread = 0;
        cycle(s_r);
        check("lu_stall_cycles", 32'(stall_cycles), 32'd1);
        $display("load-use: stall_cycles=%0d", stall_cycles);

        // Taken branch squashes a HLT in ID.
        do_reset();
        s_r = s_halt; s_r.br = 1;
        cycle(s_r);
        check("br_halt_halted", 32'(halted), 32'd0);
        check("br_halt_flush_count", 32'(flush_count), 32'd1);
        $display("branch over HLT: halted=%0d flush_count=%0d", halted, flush_count);

        // IN acknowledged after 5 wait cycles.
        do_reset();
        cycle(s_io);
        for (int i = 0; i < 5; i++) begin
            check("io_wait_req", 32'(io_req), 32'd1);
            cycle(s_io);
        end
        s_r = s_io; s_r.ack = 1;
        apply(s_r);
        @(negedge clk);
        check("io_release_bubble", 32'(idex_bubble), 32'd0);
        check("io_release_pc_en", 32'(pc_en), 32'd1);
        @(posedge clk);
        #1;
        m_mode = 0;
        apply(idle);
        check("io_ack_stall_cycles", 32'(stall_cycles), 32'd6);
        check("io_ack_io_req", 32'(io_req), 32'd0);
        check("io_ack_io_err", 32'(io_err), 32'd0);
        $display("IO ack: stall_cycles=%0d io_err=%0d", stall_cycles, io_err);

        // IN never acknowledged: released by timeout, io_err sticks.
        do_reset();
        cycle(s_io);
        n = 0;
        while (io_req && n < 20) begin
            cycle(s_io);
            n++;
        end
        check("timeout_wait_cycles", 32'(n), 32'(TO));
        check("timeout_io_err", 32'(io_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(idle);
        check("timeout_io_err_sticky", 32'(io_err), 32'd1);
        $display("IO timeout: wait_cycles=%0d io_err=%0d", n, io_err);

        // Reset during IO_WAIT drops io_req at once.
        do_reset();
        cycle(s_io);
        cycle(s_io);
        check("midwait_io_req", 32'(io_req), 32'd1);
        do_reset();

        // HLT freezes the core until reset.
        cycle(s_halt);
        for (int i = 0; i < 6; i++) cycle(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, i[0], 1, 0));
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc_en", 32'(pc_en), 32'd0);
        do_reset();
        check("halt_reset_halted", 32'(halted), 32'd0);
        $display("HLT: frozen until reset, halted=%0d", halted);

        // Stall counter saturation and clear-over-increment.
        do_reset();
        for (int i = 0; i < CNT_MAX + 5; i++) cycle(s_lu);
        check("sat_stall_cycles", 32'(stall_cycles), 32'(CNT_MAX));
        s_r = s_lu; s_r.clr = 1;
        cycle(s_r);
        check("clr_stall_cycles", 32'(stall_cycles), 32'd0);
        $display("saturation: stall_cycles cleared to %0d", stall_cycles);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s_r.valid   = 1'($urandom_range(0, 3) != 0);
            s_r.rs      = 3'($urandom_range(0, 3));
            s_r.rt      = 3'($urandom_range(0, 3));
            s_r.use_rs  = 1'($urandom);
            s_r.use_rt  = 1'($urandom);
            s_r.halt    = 1'($urandom_range(0, 31) == 0);
            s_r.io      = 1'($urandom_range(0, 7) == 0);
            s_r.memread = 1'($urandom_range(0, 2) == 0);
            s_r.dst     = 3'($urandom_range(0, 3));
            s_r.br      = 1'($urandom_range(0, 5) == 0);
            s_r.ack     = 1'($urandom_range(0, 5) == 0);
            s_r.clr     = 1'($urandom_range(0, 63) == 0);
            cycle(s_r);
            if (m_mode == 2 && $urandom_range(0, 7) == 0) do_reset();
        end
        $display("random: 3000 cycles applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
